// File: rtl/uart_rx_fifo_param.sv
// UART receiver with runtime parity mode and a show-ahead FIFO of
// {data, parity_err, frame_err} entries, plus overrun and fill-level status.
module uart_rx_fifo_param #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            i_Clock,
  input  logic                            i_Reset,
  input  logic                            i_Rx_Serial,
  input  logic [1:0]                      i_Parity_Mode,
  input  logic                            i_Read_Flag,
  input  logic                            i_Clear_Err,
  output logic [DATA_BITS-1:0]            o_Rx_Byte,
  output logic                            o_Parity_Err,
  output logic                            o_Frame_Err,
  output logic                            o_Rx_DV,
  output logic                            o_Empty,
  output logic                            o_Full,
  output logic [$clog2(FIFO_DEPTH):0]     o_Count,
  output logic                            o_Overrun,
  output logic [2:0]                      o_SM_Main
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_t;

  state_t                r_State;
  logic                  r_Rx_Meta, r_Rx_Sync;
  logic [CNT_W-1:0]      r_Clk_Cnt;
  logic [IDX_W-1:0]      r_Bit_Idx;
  logic [DATA_BITS-1:0]  r_Data;
  logic [1:0]            r_Mode;
  logic                  r_Par_Err;
  logic [EW-1:0]         r_Mem [FIFO_DEPTH];
  logic [AW-1:0]         r_Wr_Ptr, r_Rd_Ptr;
  logic [CW-1:0]         r_Count;
  logic                  r_Rx_DV, r_Overrun;

  logic                  w_Par_En, w_Stop_Smp, w_Full, w_Empty;
  logic                  w_Pop, w_Push, w_Drop;
  logic [EW-1:0]         w_Head;

  // Two-flop synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Rx_Meta <= 1'b1;
      r_Rx_Sync <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx_Sync <= r_Rx_Meta;
    end
  end

  // Parity bit is present only for even (01) and odd (10); 00 and 11 mean none
  assign w_Par_En   = (r_Mode == 2'b01) || (r_Mode == 2'b10);
  assign w_Stop_Smp = (r_State == S_STOP) && (r_Clk_Cnt == CNT_LAST);

  // Receive state machine: start validation, data shift, parity and stop sampling
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State   <= S_IDLE;
      r_Clk_Cnt <= '0;
      r_Bit_Idx <= '0;
      r_Data    <= '0;
      r_Mode    <= 2'b00;
      r_Par_Err <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: begin
          r_Clk_Cnt <= '0;
          r_Bit_Idx <= '0;
          if (!r_Rx_Sync) begin
            r_State   <= S_START;
            r_Mode    <= i_Parity_Mode;
            r_Par_Err <= 1'b0;
          end
        end
        S_START: begin
          if (r_Clk_Cnt == CNT_HALF) begin
            r_Clk_Cnt <= '0;
            r_State   <= r_Rx_Sync ? S_IDLE : S_DATA;
          end else begin
            r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_Clk_Cnt != CNT_LAST) begin
            r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
          end else begin
            r_Clk_Cnt         <= '0;
            r_Data[r_Bit_Idx] <= r_Rx_Sync;
            if (r_Bit_Idx == IDX_LAST) begin
              r_Bit_Idx <= '0;
              r_State   <= w_Par_En ? S_PARITY : S_STOP;
            end else begin
              r_Bit_Idx <= r_Bit_Idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (r_Clk_Cnt != CNT_LAST) begin
            r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
          end else begin
            r_Clk_Cnt <= '0;
            // Odd mode (10) expects an overall XOR of 1, so fold mode bit in
            r_Par_Err <= ^{r_Data, r_Rx_Sync, r_Mode[1]};
            r_State   <= S_STOP;
          end
        end
        S_STOP: begin
          if (r_Clk_Cnt != CNT_LAST) begin
            r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
          end else begin
            r_Clk_Cnt <= '0;
            r_State   <= S_CLEANUP;
          end
        end
        S_CLEANUP: r_State <= S_IDLE;
        default:   r_State <= S_IDLE;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still take the push
  assign w_Empty = (r_Count == '0);
  assign w_Full  = (r_Count == CNT_FULL);
  assign w_Pop   = i_Read_Flag && !w_Empty;
  assign w_Push  = w_Stop_Smp && (!w_Full || w_Pop);
  assign w_Drop  = w_Stop_Smp && !w_Push;

  // Entry storage; no reset needed since pointers/count define validity
  always_ff @(posedge i_Clock) begin
    if (w_Push) r_Mem[r_Wr_Ptr] <= {r_Data, r_Par_Err, ~r_Rx_Sync};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      if (w_Pop)  r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      case ({w_Push, w_Pop})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase
    end
  end

  // Accept pulse and sticky overrun; a new drop wins over a clear
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Rx_DV   <= 1'b0;
      r_Overrun <= 1'b0;
    end else begin
      r_Rx_DV <= w_Push;
      if (w_Drop)           r_Overrun <= 1'b1;
      else if (i_Clear_Err) r_Overrun <= 1'b0;
    end
  end

  assign w_Head       = r_Mem[r_Rd_Ptr];
  assign o_Rx_Byte    = w_Empty ? '0 : w_Head[EW-1:2];
  assign o_Parity_Err = w_Empty ? 1'b0 : w_Head[1];
  assign o_Frame_Err  = w_Empty ? 1'b0 : w_Head[0];
  assign o_Rx_DV      = r_Rx_DV;
  assign o_Empty      = w_Empty;
  assign o_Full       = w_Full;
  assign o_Count      = r_Count;
  assign o_Overrun    = r_Overrun;
  assign o_SM_Main    = r_State;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param: table of single frames plus
// hand sequences for overrun, push/pop-when-full, glitch and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_fifo_param;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Rx_Serial = 1'b1;
  logic [1:0] i_Parity_Mode = 2'b00;
  logic       i_Read_Flag = 1'b0;
  logic       i_Clear_Err = 1'b0;
  logic [7:0] o_Rx_Byte;
  logic       o_Parity_Err, o_Frame_Err, o_Rx_DV, o_Empty, o_Full, o_Overrun;
  logic [2:0] o_Count;
  logic [2:0] o_SM_Main;

  int errors = 0;
  int checks = 0;
  int dv_cnt = 0;

  uart_rx_fifo_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_Serial(i_Rx_Serial),
    .i_Parity_Mode(i_Parity_Mode), .i_Read_Flag(i_Read_Flag),
    .i_Clear_Err(i_Clear_Err), .o_Rx_Byte(o_Rx_Byte),
    .o_Parity_Err(o_Parity_Err), .o_Frame_Err(o_Frame_Err), .o_Rx_DV(o_Rx_DV),
    .o_Empty(o_Empty), .o_Full(o_Full), .o_Count(o_Count),
    .o_Overrun(o_Overrun), .o_SM_Main(o_SM_Main)
  );

  always #2 i_Clock = ~i_Clock;

  // Count accept pulses, sampled away from the active edge
  always @(negedge i_Clock) begin
    if (o_Rx_DV === 1'b1) dv_cnt <= dv_cnt + 1;
  end

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       perr;
    logic       ferr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bit period: drive on a falling edge, hold for 4 clocks
  task automatic drive_bit(input logic b);
    @(negedge i_Clock);
    i_Rx_Serial = b;
    repeat (3) @(negedge i_Clock);
  endtask

  // Full frame; optional pop lands on the clock edge that samples the stop bit
  task automatic send_frame(input logic [1:0] mode, input logic [7:0] data,
                            input logic par, input logic stop, input logic pop);
    i_Parity_Mode = mode;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (mode == 2'b01 || mode == 2'b10) drive_bit(par);
    drive_bit(stop);
    @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    i_Read_Flag = pop;
    @(negedge i_Clock);
    i_Read_Flag = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge i_Clock);
    i_Read_Flag = 1'b1;
    @(negedge i_Clock);
    i_Read_Flag = 1'b0;
  endtask

  vec_t vecs[8];
  int   d0;
  logic [7:0] exp_b;

  initial begin
    vecs[0] = '{"even_ok",    2'b01, 8'hC9, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"even_bad",   2'b01, 8'hC9, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"odd_bad",    2'b10, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{"odd_ok",     2'b10, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"none_stop0", 2'b00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{"none_ok",    2'b00, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"mode3_none", 2'b11, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"odd_ff",     2'b10, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (4) @(negedge i_Clock);
    i_Reset = 1'b0;
    @(negedge i_Clock);
    chk("rst_empty", o_Empty, 1);
    chk("rst_full", o_Full, 0);
    chk("rst_count", o_Count, 0);
    chk("rst_byte", o_Rx_Byte, 0);
    chk("rst_ovr", o_Overrun, 0);
    chk("rst_dv", o_Rx_DV, 0);
    chk("rst_state", o_SM_Main, 0);

    // Single frames: store, inspect head, pop, check empty head reads 0
    for (int v = 0; v < 8; v++) begin
      d0 = dv_cnt;
      send_frame(vecs[v].mode, vecs[v].data, vecs[v].par, vecs[v].stop, 1'b0);
      repeat (3) @(negedge i_Clock);
      chk({vecs[v].name, "_byte"}, o_Rx_Byte, vecs[v].data);
      chk({vecs[v].name, "_perr"}, o_Parity_Err, vecs[v].perr);
      chk({vecs[v].name, "_ferr"}, o_Frame_Err, vecs[v].ferr);
      chk({vecs[v].name, "_count"}, o_Count, 1);
      chk({vecs[v].name, "_dv"}, dv_cnt - d0, 1);
      pop_one();
      chk({vecs[v].name, "_empty"}, o_Empty, 1);
      chk({vecs[v].name, "_ebyte"}, {o_Rx_Byte, o_Parity_Err, o_Frame_Err}, 0);
    end

    // Overrun: five frames into four slots
    d0 = dv_cnt;
    for (int i = 1; i <= 5; i++) send_frame(2'b00, 8'(i), 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge i_Clock);
    chk("ovr_count", o_Count, 4);
    chk("ovr_full", o_Full, 1);
    chk("ovr_flag", o_Overrun, 1);
    chk("ovr_dv", dv_cnt - d0, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_order", o_Rx_Byte, 32'(i));
      pop_one();
    end
    chk("ovr_drained", o_Empty, 1);
    chk("ovr_sticky", o_Overrun, 1);
    @(negedge i_Clock);
    i_Clear_Err = 1'b1;
    @(negedge i_Clock);
    i_Clear_Err = 1'b0;
    chk("ovr_clear", o_Overrun, 0);

    // Full FIFO with a pop on the stop-sample edge: push accepted, no overrun
    d0 = dv_cnt;
    for (int i = 0; i < 4; i++) send_frame(2'b00, 8'h11 + 8'(i), 1'b0, 1'b1, 1'b0);
    chk("pp_full", o_Full, 1);
    send_frame(2'b00, 8'h77, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge i_Clock);
    chk("pp_count", o_Count, 4);
    chk("pp_ovr", o_Overrun, 0);
    chk("pp_dv", dv_cnt - d0, 5);
    for (int i = 0; i < 4; i++) begin
      exp_b = (i == 3) ? 8'h77 : 8'h12 + 8'(i);
      chk("pp_order", o_Rx_Byte, exp_b);
      pop_one();
    end
    chk("pp_empty", o_Empty, 1);

    // One-clock glitch: START entered, then abandoned with nothing stored
    d0 = dv_cnt;
    @(negedge i_Clock);
    i_Rx_Serial = 1'b0;
    @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    repeat (2) @(negedge i_Clock);
    chk("gl_start", o_SM_Main, 1);
    repeat (6) @(negedge i_Clock);
    chk("gl_idle", o_SM_Main, 0);
    chk("gl_count", o_Count, 0);
    chk("gl_dv", dv_cnt - d0, 0);

    // Reset during DATA flushes the FIFO and the partial frame
    send_frame(2'b00, 8'hAB, 1'b0, 1'b1, 1'b0);
    chk("mr_pre", o_Count, 1);
    i_Parity_Mode = 2'b01;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    chk("mr_data", o_SM_Main, 2);
    @(negedge i_Clock);
    i_Reset = 1'b1;
    i_Rx_Serial = 1'b1;
    @(negedge i_Clock);
    chk("mr_state", o_SM_Main, 0);
    chk("mr_count", o_Count, 0);
    chk("mr_empty", o_Empty, 1);
    i_Reset = 1'b0;
    repeat (4) @(negedge i_Clock);
    send_frame(2'b01, 8'hC9, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge i_Clock);
    chk("mr_byte", o_Rx_Byte, 8'hC9);
    chk("mr_flags", {o_Parity_Err, o_Frame_Err}, 0);
    chk("mr_count1", o_Count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
